muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64, even).
REQ-002 SHALL have parameter FAST_MUL, default 0; 1 = single-cycle multiply path, 0 = iterative shift-add.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit can accept a request (high only in IDLE).
REQ-007 func3  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 a, b  input  XLEN each  operands (a = rs1, b = rs2).
REQ-009 flush  input  1  abandon in-flight operation.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 r  output  XLEN  result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Accept SHALL occur on an edge with in_valid && in_ready; func3, a and b SHALL be captured then and ignored afterwards.
REQ-015 States SHALL be IDLE, CALC, FIX, DONE; IDLE->CALC on accept; CALC->FIX when iteration counter reaches XLEN-1; FIX->DONE; DONE->IDLE on out_valid && out_ready.
REQ-016 Divide and iterative-multiply ops: out_valid SHALL rise exactly XLEN+2 clocks after the accept edge.
REQ-017 FAST_MUL=1 multiply ops: IDLE->FIX directly; out_valid SHALL rise 2 clocks after accept.
REQ-018 Divide by zero SHALL bypass CALC (IDLE->DONE; out_valid 1 clock after accept): DIV/DIVU -> all ones; REM/REMU -> a.
REQ-019 Signed overflow (DIV/REM, a = most-negative, b = -1) SHALL bypass CALC the same way: DIV -> a; REM -> 0.
REQ-020 Signed ops SHALL iterate on magnitudes; FIX SHALL negate: quotient if sign(a)!=sign(b), remainder if sign(a), product if sign(a)^sign(b) (MULHSU: sign(a) only).
REQ-021 Multiply SHALL form the full 2*XLEN product; MUL returns low half, MULH/MULHSU/MULHU high half.
REQ-022 Division SHALL be restoring, one quotient bit per CALC cycle; remainder sign follows dividend (truncating division).
REQ-023 r and out_valid SHALL hold stable in DONE until out_ready; r SHALL be 0 whenever out_valid is low.
REQ-024 flush in any state SHALL force IDLE on the next edge, drop out_valid, discard the result; flush on an accept edge SHALL cancel that accept.
REQ-025 out_ready while DONE and in_valid on the same cycle: DONE->IDLE; new request accepted no earlier than the following edge (no back-to-back accept).
REQ-026 in_ready SHALL be combinational from state only (no path from in_valid).

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter 0, out_valid 0, r 0, busy 0, in_ready 1 after release; a mid-operation reset discards the operation.

Structure
REQ-028 func3 op codes and state encodings SHALL live in the shared defines file next to the ALU op codes.
REQ-029 The single-iteration divide step (compare/subtract/shift) SHALL be sub-module muldiv_div_step, XLEN-parametrised, purely combinational.
REQ-030 Iteration counter SHALL be $clog2(XLEN) bits wide and wrap to 0 on leaving CALC.

Verification
REQ-031 XLEN=32, DIV a=-7, b=2 -> r=0xFFFFFFFD, out_valid exactly 34 clocks after accept.
REQ-032 REM a=-7, b=2 -> 0xFFFFFFFF; REMU a=7, b=0 -> 7 after 1 clock; DIVU a=5, b=0 -> 0xFFFFFFFF.
REQ-033 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0, both 1 clock latency.
REQ-034 MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF; MULHU same -> 1; run with FAST_MUL=0 and 1, checking 34/2 clock latency.
REQ-035 out_ready held low 10 cycles in DONE -> r stable and in_ready low throughout; flush asserted mid-CALC -> IDLE next edge, no out_valid.
REQ-036 rst_n pulsed low mid-CALC (asynchronous to clk) -> outputs zero immediately; next DIVU 100/7 -> 14.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes and state encodings for the integer ALU and the
// sequential multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input md_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input md_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit one quotient bit.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // NOTE: every output is assigned on every path so no latch is inferred.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M-style multiply/divide unit: iterates on operand magnitudes
// in CALC, applies the result sign in FIX, holds the result in DONE.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] r,
  output logic            busy
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state, state_nxt;
  logic [CW-1:0]   cnt;
  md_op_e          op;
  logic            neg;
  logic [XLEN-1:0] hi, lo, opb, res;

  md_op_e            op_in;
  logic              accept, div_zero, div_ovf, neg_in;
  logic [XLEN-1:0]   a_mag, b_mag, bypass_res, fix_res;
  logic [XLEN-1:0]   div_rem, div_quo;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_fast, prod_signed;

  assign op_in     = md_op_e'(func3);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign r         = out_valid ? res : '0;
  assign accept    = in_valid && in_ready && !flush;

  // Request decode: magnitudes, result sign and the CALC-bypass cases.
  always_comb begin
    a_mag    = (op_a_signed(op_in) && a[XLEN-1]) ? -a : a;
    b_mag    = (op_b_signed(op_in) && b[XLEN-1]) ? -b : b;
    div_zero = is_div(op_in) && (b == '0);
    div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (a == MOST_NEG) && (b == '1);
    case (op_in)
      OP_MULH, OP_DIV:   neg_in = a[XLEN-1] ^ b[XLEN-1];
      OP_MULHSU, OP_REM: neg_in = a[XLEN-1];
      default:           neg_in = 1'b0;
    endcase
    if (div_zero) bypass_res = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : a;
    else          bypass_res = (op_in == OP_DIV) ? a : '0;
  end

  if (FAST_MUL != 0) begin : g_fast
    assign prod_fast = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  end else begin : g_iter
    assign prod_fast = '0;
  end

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem     (hi),
    .quo     (lo),
    .divisor (opb),
    .rem_nxt (div_rem),
    .quo_nxt (div_quo)
  );

  // Shift-add: multiplier in lo drains out the bottom as product bits enter.
  assign mul_sum = {1'b0, hi} + {1'b0, opb & {XLEN{lo[0]}}};

  always_comb begin
    prod_signed = neg ? -{hi, lo} : {hi, lo};
    case (op)
      OP_MUL:                       fix_res = lo;
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_signed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = neg ? -lo : lo;
      default:                      fix_res = neg ? -hi : hi;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (div_zero || div_ovf)              state_nxt = DONE;
        else if (FAST_MUL != 0 && !is_div(op_in)) state_nxt = FIX;
        else                                  state_nxt = CALC;
      end
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= OP_MUL;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      opb   <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == CALC && state_nxt == CALC) ? cnt + CW'(1) : '0;
      case (state)
        IDLE: if (accept) begin
          op  <= op_in;
          neg <= neg_in;
          res <= bypass_res;
          if (is_div(op_in)) begin
            hi  <= '0;
            lo  <= a_mag;
            opb <= b_mag;
          end else if (FAST_MUL != 0) begin
            {hi, lo} <= prod_fast;
            opb      <= b_mag;
          end else begin
            hi  <= '0;
            lo  <= b_mag;
            opb <= a_mag;
          end
        end
        CALC: begin
          if (is_div(op)) {hi, lo} <= {div_rem, div_quo};
          else            {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
        end
        FIX:     res <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: iterative and fast-multiply instances, vector table,
// random ops against a behavioural model, and stall/flush/reset sequences.
module tb_muldiv_seq;

  localparam int XLEN = 32;

  typedef struct {
    bit          fast;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r_exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    int          lat;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_s, in_valid_f, flush, out_ready;
  logic [2:0]  func3;
  logic [31:0] a, b;
  logic        in_ready_s, in_ready_f, out_valid_s, out_valid_f, busy_s, busy_f;
  logic [31:0] r_s, r_f;

  int  checks = 0;
  int  errors = 0;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(XLEN), .FAST_MUL(0)) u_iter (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .func3(func3), .a(a), .b(b), .flush(flush), .out_valid(out_valid_s),
    .out_ready(out_ready), .r(r_s), .busy(busy_s)
  );

  muldiv_seq #(.XLEN(XLEN), .FAST_MUL(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_f), .in_ready(in_ready_f),
    .func3(func3), .a(a), .b(b), .flush(flush), .out_valid(out_valid_f),
    .out_ready(out_ready), .r(r_f), .busy(busy_f)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_r(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xs, ys, xu, yu, p;
    int xi, yi;
    logic ovf;
    xs  = {{32{x[31]}}, x};
    ys  = {{32{y[31]}}, y};
    xu  = {32'd0, x};
    yu  = {32'd0, y};
    xi  = int'(x);
    yi  = int'(y);
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = xu * yu; return p[31:0];  end
      3'd1: begin p = xs * ys; return p[63:32]; end
      3'd2: begin p = xs * yu; return p[63:32]; end
      3'd3: begin p = xu * yu; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf)    return x;
        return 32'(xi / yi);
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf)    return 32'd0;
        return 32'(xi % yi);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input bit fast, input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    if (f3[2] && (y == 0 || ((f3 == 3'd4 || f3 == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
      return 1;
    if (!f3[2] && fast) return 2;
    return 34;
  endfunction

  // Wait for the result, counting edges from the accept edge; bounded.
  task automatic wait_result(input bit fast, output int lat);
    bit seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      seen = fast ? out_valid_f : out_valid_s;
    end
  endtask

  task automatic run_op(input bit fast, input logic [2:0] f3, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_r, input int exp_lat,
                        input string tag);
    sb_t got;
    int  lat;
    @(negedge clk);
    check({tag, " in_ready"}, fast ? in_ready_f : in_ready_s, 1);
    func3     = f3;
    a         = av;
    b         = bv;
    out_ready = 1'b1;
    if (fast) in_valid_f = 1'b1; else in_valid_s = 1'b1;
    sb_q.push_back('{r: exp_r, lat: exp_lat});
    @(posedge clk);
    #1;
    in_valid_f = 1'b0;
    in_valid_s = 1'b0;
    func3      = 3'($urandom);
    a          = $urandom;
    b          = $urandom;
    wait_result(fast, lat);
    got = sb_q.pop_front();
    check({tag, " latency"}, lat, got.lat);
    check({tag, " r"}, fast ? r_f : r_s, got.r);
  endtask

  vec_t        vecs [20];
  int          lat;
  bit          seen;
  logic [2:0]  rf3;
  logic [31:0] x, y;

  initial begin
    vecs = '{
      '{0, 3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34},
      '{0, 3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34},
      '{0, 3'd7, 32'd7,         32'd0,        32'd7,         1},
      '{0, 3'd5, 32'd5,         32'd0,        32'hFFFF_FFFF, 1},
      '{0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1},
      '{0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34},
      '{1, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2},
      '{0, 3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 34},
      '{1, 3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 2},
      '{0, 3'd3, 32'hFFFF_FFFF, 32'd2,        32'd1,         34},
      '{1, 3'd3, 32'hFFFF_FFFF, 32'd2,        32'd1,         2},
      '{0, 3'd0, 32'h1234_5678, 32'h10,       32'h2345_6780, 34},
      '{1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        2},
      '{0, 3'd4, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34},
      '{0, 3'd6, 32'd100,       32'hFFFF_FFF9, 32'd2,        34},
      '{0, 3'd4, 32'h8000_0000, 32'd1,        32'h8000_0000, 34},
      '{0, 3'd4, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, 1},
      '{0, 3'd6, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 1},
      '{1, 3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34}
    };

    rst_n      = 1'b0;
    in_valid_s = 1'b0;
    in_valid_f = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    func3      = 3'd0;
    a          = '0;
    b          = '0;
    #12;
    check("reset in_ready", in_ready_s, 1);
    check("reset out_valid", out_valid_s, 0);
    check("reset r", r_s, 0);
    check("reset busy", busy_s, 0);
    check("reset busy fast", busy_f, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      run_op(vecs[i].fast, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].r_exp, vecs[i].lat,
             $sformatf("vec%0d", i));

    for (int i = 0; i < 14; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      x   = $urandom;
      y   = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(i % 2 == 1, rf3, x, y, ref_r(rf3, x, y), ref_lat(i % 2 == 1, rf3, x, y),
             $sformatf("rand%0d", i));
    end

    // Result held while the consumer stalls; DONE edge never accepts.
    @(negedge clk);
    func3 = 3'd5; a = 32'd100; b = 32'd7; in_valid_s = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid_s = 1'b0;
    wait_result(1'b0, lat);
    check("stall latency", lat, 34);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall r", r_s, 14);
      check("stall in_ready", in_ready_s, 0);
      check("stall out_valid", out_valid_s, 1);
    end
    func3 = 3'd4; a = 32'hFFFF_FFF9; b = 32'd2; in_valid_s = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("release out_valid", out_valid_s, 0);
    check("release in_ready", in_ready_s, 1);
    @(posedge clk);
    #1 in_valid_s = 1'b0;
    wait_result(1'b0, lat);
    check("after stall latency", lat, 34);
    check("after stall r", r_s, 32'hFFFF_FFFD);

    // Flush mid-CALC and flush on an accept edge.
    @(negedge clk);
    func3 = 3'd4; a = 32'd1000; b = 32'd3; in_valid_s = 1'b1;
    @(posedge clk);
    #1 in_valid_s = 1'b0;
    repeat (5) @(negedge clk);
    check("calc busy", busy_s, 1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush busy", busy_s, 0);
    check("flush in_ready", in_ready_s, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_s) seen = 1'b1;
    end
    check("flush no out_valid", seen, 0);
    @(negedge clk);
    func3 = 3'd5; a = 32'd10; b = 32'd3; in_valid_s = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid_s = 1'b0; flush = 1'b0;
    check("flush on accept busy", busy_s, 0);

    // Asynchronous reset with one unit in DONE and the other mid-CALC.
    @(negedge clk);
    func3 = 3'd3; a = 32'hFFFF_FFFF; b = 32'd2; in_valid_f = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid_f = 1'b0;
    @(negedge clk);
    func3 = 3'd4; a = 32'd12345; b = 32'd67; in_valid_s = 1'b1;
    @(posedge clk);
    #1 in_valid_s = 1'b0;
    repeat (7) @(posedge clk);
    check("pre-reset fast out_valid", out_valid_f, 1);
    check("pre-reset fast r", r_f, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid_f, 0);
    check("async reset r", r_f, 0);
    check("async reset busy", busy_s, 0);
    check("async reset busy fast", busy_f, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    run_op(1'b0, 3'd5, 32'd100, 32'd7, 32'd14, 34, "post-reset divu");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
